ps2_key_event: RTL and testbench

Parametrised PS/2 scan-code decoder sitting between the PS/2 byte receiver (`ps2_keyboard`) and display/character logic. It pops raw bytes with the receiver's `ready`/`nextdata_n` handshake and resolves `E0` extended and `F0` break prefixes into complete key events. It tracks currently held keys to suppress typematic repeats and buffers events in a FIFO behind a valid/ready port. It replaces ad-hoc per-key combinational state machines in `top`.

---
 rtl/ps2_pkg.sv | 31 +++
 rtl/ps2_evt_fifo.sv | 66 ++++++
 rtl/ps2_key_event.sv | 279 +++++++++++++++++++++++++++
 tb/tb_ps2_key_event.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// Shared constants, FSM encoding and event layout for the PS/2 key-event decoder.
package ps2_pkg;

  // Prefix and error bytes of PS/2 scan-code set 2
  localparam logic [7:0] PS2_EXT  = 8'hE0;
  localparam logic [7:0] PS2_BRK  = 8'hF0;
  localparam logic [7:0] PS2_ERR0 = 8'h00;
  localparam logic [7:0] PS2_ERR1 = 8'hFF;

  // One event is {code[7:0], ext, brk}
  localparam int PS2_EVT_W = 10;

  // Byte fetch handshake with the receiver
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACK  = 2'd1,
    ST_GAP  = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [7:0] code;
    logic       ext;
    logic       brk;
  } ps2_evt_t;

  // Bytes the keyboard uses to signal buffer overrun / internal error
  function automatic logic is_err_byte(input logic [7:0] b);
    return (b == PS2_ERR0) || (b == PS2_ERR1);
  endfunction

endpackage

// File: rtl/ps2_evt_fifo.sv
// Synchronous show-ahead FIFO: the head entry is visible on rd_data whenever
// the FIFO is not empty, and pop advances to the next entry.
module ps2_evt_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             pop,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_reg;
  logic [AW-1:0]    rd_ptr_reg;
  logic [AW:0]      count_reg;
  logic             wr_en;
  logic             rd_en;

  assign full  = (count_reg == (AW+1)'(DEPTH));
  assign empty = (count_reg == '0);

  // A push into a full FIFO is still accepted when the head leaves in the same cycle
  assign rd_en = pop && !empty;
  assign wr_en = push && (!full || rd_en);

  // Storage array, no reset so it maps onto distributed/block memory
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr_reg] <= wr_data;
    end
  end

  // Pointers and occupancy; depth is a power of two so pointers wrap naturally
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (wr_en) begin
        wr_ptr_reg <= wr_ptr_reg + AW'(1);
      end
      if (rd_en) begin
        rd_ptr_reg <= rd_ptr_reg + AW'(1);
      end
      case ({wr_en, rd_en})
        2'b10:   count_reg <= count_reg + (AW+1)'(1);
        2'b01:   count_reg <= count_reg - (AW+1)'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  // Head is forced to zero while empty so stale entries never show
  always_comb begin
    rd_data = empty ? '0 : mem[rd_ptr_reg];
  end

endmodule

// File: rtl/ps2_key_event.sv
// PS/2 scan-code decoder: pops bytes from the receiver, folds E0/F0 prefixes
// into complete key events, tracks held keys to filter typematic repeats and
// queues events behind a valid/ready port.
module ps2_key_event
  import ps2_pkg::*;
#(
  parameter int FIFO_DEPTH   = 8,
  parameter int N_HELD       = 4,
  parameter int SUPPRESS_RPT = 1,
  parameter int TIMEOUT      = 1_000_000,
  parameter int CNT_W        = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [7:0]                    in_data,
  input  logic                          in_ready,
  output logic                          in_nextdata_n,
  input  logic                          clr_stat,
  output logic                          evt_valid,
  input  logic                          evt_ready,
  output logic [7:0]                    evt_code,
  output logic                          evt_ext,
  output logic                          evt_brk,
  output logic [CNT_W-1:0]              press_cnt,
  output logic [$clog2(N_HELD+1)-1:0]   held_cnt,
  output logic                          evt_ovf,
  output logic                          held_ovf,
  output logic                          seq_err
);

  localparam int HCW = $clog2(N_HELD + 1);
  localparam int TW  = $clog2(TIMEOUT + 1);

  // ---------------------------------------------------------------- fetch FSM
  fetch_state_e state_reg;
  fetch_state_e state_next;
  logic         ack;
  logic [7:0]   byte_reg;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next state: one byte every three cycles at most
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: if (in_ready) state_next = ST_ACK;
      ST_ACK:  state_next = ST_GAP;
      ST_GAP:  state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // FSM outputs: pop strobe to the receiver and the classify enable
  always_comb begin
    in_nextdata_n = 1'b1;
    ack           = 1'b0;
    if (state_reg == ST_ACK) begin
      in_nextdata_n = 1'b0;
      ack           = 1'b1;
    end
  end

  // Capture the receiver byte when leaving IDLE
  always_ff @(posedge clk) begin
    if (rst) begin
      byte_reg <= '0;
    end else if (state_reg == ST_IDLE && in_ready) begin
      byte_reg <= in_data;
    end
  end

  // ---------------------------------------------------------------- classify
  logic       ext_reg;
  logic       brk_reg;
  logic       is_ext;
  logic       is_brk;
  logic       is_err;
  logic       is_final;
  logic [8:0] key_now;

  always_comb begin
    is_ext   = ack && (byte_reg == PS2_EXT);
    is_brk   = ack && (byte_reg == PS2_BRK);
    is_err   = ack && is_err_byte(byte_reg);
    is_final = ack && !(byte_reg == PS2_EXT) && !(byte_reg == PS2_BRK) && !is_err_byte(byte_reg);
    key_now  = {ext_reg, byte_reg};
  end

  // ---------------------------------------------------------------- timeout
  logic [TW-1:0] tmo_cnt_reg;
  logic          tmo_run;
  logic          tmo_fire;

  // Counts idle cycles with a pending prefix; any capture restarts it
  always_comb begin
    tmo_run  = (state_reg == ST_IDLE) && (ext_reg || brk_reg) && !in_ready;
    tmo_fire = tmo_run && (tmo_cnt_reg == TW'(TIMEOUT - 1));
  end

  // Timeout counter
  always_ff @(posedge clk) begin
    if (rst || !tmo_run || tmo_fire) begin
      tmo_cnt_reg <= '0;
    end else begin
      tmo_cnt_reg <= tmo_cnt_reg + TW'(1);
    end
  end

  // Prefix flags persist between bytes until a final code, error or timeout
  always_ff @(posedge clk) begin
    if (rst) begin
      ext_reg <= 1'b0;
      brk_reg <= 1'b0;
    end else if (is_ext) begin
      ext_reg <= 1'b1;
    end else if (is_brk) begin
      brk_reg <= 1'b1;
    end else if (is_err || is_final || tmo_fire) begin
      ext_reg <= 1'b0;
      brk_reg <= 1'b0;
    end
  end

  // ---------------------------------------------------------------- held table
  logic             held_vld_reg [N_HELD];
  logic [8:0]       held_key_reg [N_HELD];
  logic [N_HELD-1:0] held_vld_vec;
  logic [N_HELD-1:0] match;
  logic [N_HELD-1:0] ins_onehot;
  logic             any_match;
  logic             held_full;
  logic             fin_make;
  logic             fin_brk;
  logic             suppress;
  logic             do_insert;
  logic             do_remove;
  logic             hovf_set;
  logic             push_evt;
  logic             press_inc;

  // Parallel compare of the incoming key against every occupied entry
  for (genvar gi = 0; gi < N_HELD; gi++) begin : g_match
    assign held_vld_vec[gi] = held_vld_reg[gi];
    assign match[gi]        = held_vld_reg[gi] && (held_key_reg[gi] == key_now);
  end

  // Lowest free slot gets the next inserted key
  always_comb begin
    logic found;
    found      = 1'b0;
    ins_onehot = '0;
    for (int i = 0; i < N_HELD; i++) begin
      if (!held_vld_vec[i] && !found) begin
        ins_onehot[i] = 1'b1;
        found         = 1'b1;
      end
    end
  end

  // Event decisions for the byte being acknowledged. A key already in the
  // table is never inserted a second time, so each key occupies at most one
  // entry and a single break releases it even when repeats are passed through.
  always_comb begin
    any_match = |match;
    held_full = &held_vld_vec;
    fin_make  = is_final && !brk_reg;
    fin_brk   = is_final && brk_reg;
    suppress  = fin_make && any_match && (SUPPRESS_RPT != 0);
    do_insert = fin_make && !any_match && !held_full;
    hovf_set  = fin_make && !any_match && held_full;
    do_remove = fin_brk && any_match;
    press_inc = fin_make && !suppress;
    push_evt  = fin_brk || press_inc;
  end

  // Per-entry update: release on break, claim on insert
  for (genvar gi = 0; gi < N_HELD; gi++) begin : g_entry
    always_ff @(posedge clk) begin
      if (rst) begin
        held_vld_reg[gi] <= 1'b0;
        held_key_reg[gi] <= '0;
      end else if (do_remove && match[gi]) begin
        held_vld_reg[gi] <= 1'b0;
      end else if (do_insert && ins_onehot[gi]) begin
        held_vld_reg[gi] <= 1'b1;
        held_key_reg[gi] <= key_now;
      end
    end
  end

  // Occupancy is the population count of the valid bits
  always_comb begin
    held_cnt = '0;
    for (int i = 0; i < N_HELD; i++) begin
      held_cnt = held_cnt + HCW'(held_vld_vec[i]);
    end
  end

  // ---------------------------------------------------------------- event FIFO
  ps2_evt_t evt_in;
  ps2_evt_t evt_head;
  logic     fifo_full;
  logic     fifo_empty;
  logic     evt_pop;

  // brk_reg already equals the release/press flag of the final code
  assign evt_in  = '{code: byte_reg, ext: ext_reg, brk: brk_reg};
  assign evt_pop = evt_valid && evt_ready;

  ps2_evt_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (PS2_EVT_W)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (push_evt),
    .wr_data (evt_in),
    .pop     (evt_pop),
    .rd_data (evt_head),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign evt_valid = !fifo_empty;
  assign evt_code  = evt_head.code;
  assign evt_ext   = evt_head.ext;
  assign evt_brk   = evt_head.brk;

  // ---------------------------------------------------------------- statistics
  logic [CNT_W-1:0] press_cnt_reg;
  logic             evt_ovf_reg;
  logic             held_ovf_reg;
  logic             seq_err_reg;
  logic             evt_ovf_set;
  logic             seq_err_set;

  assign evt_ovf_set = push_evt && fifo_full && !evt_pop;
  assign seq_err_set = is_err || tmo_fire;

  // Press counter wraps; a press in the clearing cycle is still counted
  always_ff @(posedge clk) begin
    if (rst) begin
      press_cnt_reg <= '0;
    end else if (clr_stat) begin
      press_cnt_reg <= press_inc ? CNT_W'(1) : '0;
    end else if (press_inc) begin
      press_cnt_reg <= press_cnt_reg + CNT_W'(1);
    end
  end

  // Sticky flags: a set event outranks a coincident clear
  always_ff @(posedge clk) begin
    if (rst) begin
      evt_ovf_reg  <= 1'b0;
      held_ovf_reg <= 1'b0;
      seq_err_reg  <= 1'b0;
    end else begin
      if (evt_ovf_set)   evt_ovf_reg  <= 1'b1;
      else if (clr_stat) evt_ovf_reg  <= 1'b0;
      if (hovf_set)      held_ovf_reg <= 1'b1;
      else if (clr_stat) held_ovf_reg <= 1'b0;
      if (seq_err_set)   seq_err_reg  <= 1'b1;
      else if (clr_stat) seq_err_reg  <= 1'b0;
    end
  end

  assign press_cnt = press_cnt_reg;
  assign evt_ovf   = evt_ovf_reg;
  assign held_ovf  = held_ovf_reg;
  assign seq_err   = seq_err_reg;

endmodule

// File: tb/tb_ps2_key_event.sv
// Scoreboard bench for ps2_key_event: dut_a filters repeats, dut_b passes
// them through. Expected events are queued as bytes are sent; a monitor
// process pops and compares whenever a DUT hands an event over.
module tb_ps2_key_event;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] in_data = 8'h00;
  logic       in_ready_a = 1'b0;
  logic       in_ready_b = 1'b0;
  logic       clr_stat = 1'b0;
  logic       evt_ready_a = 1'b1;
  logic       evt_ready_b = 1'b1;
  logic       clr_stat_b = 1'b0;

  logic       in_nextdata_n_a, in_nextdata_n_b;
  logic       evt_valid_a, evt_valid_b;
  logic [7:0] evt_code_a, evt_code_b;
  logic       evt_ext_a, evt_ext_b;
  logic       evt_brk_a, evt_brk_b;
  logic [7:0] press_cnt_a, press_cnt_b;
  logic [2:0] held_cnt_a, held_cnt_b;
  logic       evt_ovf_a, evt_ovf_b;
  logic       held_ovf_a, held_ovf_b;
  logic       seq_err_a, seq_err_b;

  int total = 0;
  int bad   = 0;
  logic [9:0] exp_a [$];
  logic [9:0] exp_b [$];

  always #5 clk = ~clk;

  ps2_key_event #(
    .FIFO_DEPTH(8), .N_HELD(4), .SUPPRESS_RPT(1), .TIMEOUT(20), .CNT_W(8)
  ) dut_a (
    .clk(clk), .rst(rst), .in_data(in_data), .in_ready(in_ready_a),
    .in_nextdata_n(in_nextdata_n_a), .clr_stat(clr_stat),
    .evt_valid(evt_valid_a), .evt_ready(evt_ready_a), .evt_code(evt_code_a),
    .evt_ext(evt_ext_a), .evt_brk(evt_brk_a), .press_cnt(press_cnt_a),
    .held_cnt(held_cnt_a), .evt_ovf(evt_ovf_a), .held_ovf(held_ovf_a),
    .seq_err(seq_err_a)
  );

  ps2_key_event #(
    .FIFO_DEPTH(8), .N_HELD(4), .SUPPRESS_RPT(0), .TIMEOUT(20), .CNT_W(8)
  ) dut_b (
    .clk(clk), .rst(rst), .in_data(in_data), .in_ready(in_ready_b),
    .in_nextdata_n(in_nextdata_n_b), .clr_stat(clr_stat_b),
    .evt_valid(evt_valid_b), .evt_ready(evt_ready_b), .evt_code(evt_code_b),
    .evt_ext(evt_ext_b), .evt_brk(evt_brk_b), .press_cnt(press_cnt_b),
    .held_cnt(held_cnt_b), .evt_ovf(evt_ovf_b), .held_ovf(held_ovf_b),
    .seq_err(seq_err_b)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end else begin
      $display("ok   %s: %0h", name, act);
    end
  endtask

  task automatic expect_a(input logic [7:0] code, input logic ext, input logic brk);
    exp_a.push_back({code, ext, brk});
  endtask

  task automatic expect_b(input logic [7:0] code, input logic ext, input logic brk);
    exp_b.push_back({code, ext, brk});
  endtask

  // Receiver model: offer a byte until the DUT pulses in_nextdata_n low
  task automatic send(input logic [7:0] b, input bit to_b);
    bit got;
    got = 1'b0;
    @(negedge clk);
    in_data = b;
    if (to_b) in_ready_b = 1'b1;
    else      in_ready_a = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      if ((to_b ? in_nextdata_n_b : in_nextdata_n_a) == 1'b0) begin
        got = 1'b1;
        break;
      end
    end
    in_ready_a = 1'b0;
    in_ready_b = 1'b0;
    $display("byte %s %h", to_b ? "b" : "a", b);
    if (!got) begin
      total++;
      bad++;
      $display("FAIL ack_%h: got no in_nextdata_n pulse expected one", b);
    end
  endtask

  // Scoreboard side: compare each handed-over event against the queue head
  task automatic monitor_loop();
    logic [9:0] e;
    logic [9:0] g;
    forever begin
      @(negedge clk);
      if (!rst && evt_valid_a && evt_ready_a) begin
        g = {evt_code_a, evt_ext_a, evt_brk_a};
        total++;
        if (exp_a.size() == 0) begin
          bad++;
          $display("FAIL evt_a: got %h expected no event", g);
        end else begin
          e = exp_a.pop_front();
          if (g !== e) begin
            bad++;
            $display("FAIL evt_a: got %h expected %h", g, e);
          end else begin
            $display("ok   evt_a: code=%h ext=%b brk=%b", g[9:2], g[1], g[0]);
          end
        end
      end
      if (!rst && evt_valid_b && evt_ready_b) begin
        g = {evt_code_b, evt_ext_b, evt_brk_b};
        total++;
        if (exp_b.size() == 0) begin
          bad++;
          $display("FAIL evt_b: got %h expected no event", g);
        end else begin
          e = exp_b.pop_front();
          if (g !== e) begin
            bad++;
            $display("FAIL evt_b: got %h expected %h", g, e);
          end else begin
            $display("ok   evt_b: code=%h ext=%b brk=%b", g[9:2], g[1], g[0]);
          end
        end
      end
    end
  endtask

  // Bounded wait until every expected event has been delivered
  task automatic wait_drain();
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (exp_a.size() == 0 && exp_b.size() == 0 && !evt_valid_a && !evt_valid_b) break;
    end
    @(negedge clk);
    @(negedge clk);
    check("pending_a", exp_a.size(), 0);
    check("pending_b", exp_b.size(), 0);
  endtask

  task automatic pulse_clr();
    @(negedge clk);
    clr_stat = 1'b1;
    @(negedge clk);
    clr_stat = 1'b0;
    @(negedge clk);
  endtask

  logic [7:0] ovf_codes [9];

  initial begin
    ovf_codes = '{8'h15, 8'h1C, 8'h23, 8'h24, 8'h2B, 8'h2C, 8'h2D, 8'h2E, 8'h2F};
    fork
      monitor_loop();
    join_none

    // Reset state, with the receiver already offering a byte
    in_data    = 8'h15;
    in_ready_a = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("rst_nextdata_n", in_nextdata_n_a, 1);
    end
    check("rst_evt_valid", evt_valid_a, 0);
    check("rst_evt_code", evt_code_a, 0);
    check("rst_evt_ext_brk", {evt_ext_a, evt_brk_a}, 0);
    check("rst_press_cnt", press_cnt_a, 0);
    check("rst_held_cnt", held_cnt_a, 0);
    check("rst_stickies", {evt_ovf_a, held_ovf_a, seq_err_a}, 0);
    in_ready_a = 1'b0;
    @(negedge clk);
    rst = 1'b0;

    // Plain make / break
    expect_a(8'h15, 1'b0, 1'b0);
    send(8'h15, 0);
    repeat (3) @(negedge clk);
    check("held_after_make15", held_cnt_a, 1);
    check("press_after_make15", press_cnt_a, 1);
    expect_a(8'h15, 1'b0, 1'b1);
    send(8'hF0, 0);
    send(8'h15, 0);
    repeat (3) @(negedge clk);
    check("held_after_brk15", held_cnt_a, 0);
    check("press_after_brk15", press_cnt_a, 1);

    // Extended key is distinct from its plain counterpart
    expect_a(8'h75, 1'b1, 1'b0);
    send(8'hE0, 0);
    send(8'h75, 0);
    expect_a(8'h75, 1'b0, 1'b0);
    send(8'h75, 0);
    repeat (3) @(negedge clk);
    check("held_two_75", held_cnt_a, 2);
    expect_a(8'h75, 1'b1, 1'b1);
    send(8'hE0, 0);
    send(8'hF0, 0);
    send(8'h75, 0);
    repeat (3) @(negedge clk);
    check("held_after_brk_e075", held_cnt_a, 1);
    expect_a(8'h75, 1'b0, 1'b1);
    send(8'hF0, 0);
    send(8'h75, 0);
    repeat (3) @(negedge clk);
    check("held_after_brk_75", held_cnt_a, 0);
    check("press_after_75s", press_cnt_a, 3);

    // Typematic repeats: suppressed on a, passed through on b
    expect_a(8'h1C, 1'b0, 1'b0);
    expect_a(8'h1C, 1'b0, 1'b1);
    send(8'h1C, 0); send(8'h1C, 0); send(8'h1C, 0); send(8'hF0, 0); send(8'h1C, 0);
    expect_b(8'h1C, 1'b0, 1'b0);
    expect_b(8'h1C, 1'b0, 1'b0);
    expect_b(8'h1C, 1'b0, 1'b0);
    expect_b(8'h1C, 1'b0, 1'b1);
    send(8'h1C, 1); send(8'h1C, 1); send(8'h1C, 1); send(8'hF0, 1); send(8'h1C, 1);
    wait_drain();
    check("press_a_rpt", press_cnt_a, 4);
    check("press_b_rpt", press_cnt_b, 3);
    check("held_b_rpt", held_cnt_b, 0);

    pulse_clr();
    check("press_after_clr", press_cnt_a, 0);

    // FIFO and held-table overflow with the consumer stalled
    @(posedge clk);
    #2 evt_ready_a = 1'b0;
    for (int i = 0; i < 9; i++) begin
      if (i < 8) expect_a(ovf_codes[i], 1'b0, 1'b0);
      send(ovf_codes[i], 0);
    end
    repeat (3) @(negedge clk);
    check("ovf_evt_valid", evt_valid_a, 1);
    check("ovf_evt_ovf", evt_ovf_a, 1);
    check("ovf_held_cnt", held_cnt_a, 4);
    check("ovf_held_ovf", held_ovf_a, 1);
    check("ovf_press_cnt", press_cnt_a, 9);
    @(posedge clk);
    #2 evt_ready_a = 1'b1;
    wait_drain();
    pulse_clr();
    check("clr_evt_ovf", evt_ovf_a, 0);
    check("clr_held_ovf", held_ovf_a, 0);
    check("clr_press", press_cnt_a, 0);

    // Reset mid-sequence drops the E0 prefix and the held table
    send(8'hE0, 0);
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("rst_mid_held", held_cnt_a, 0);
    check("rst_mid_valid", evt_valid_a, 0);
    expect_a(8'h75, 1'b0, 1'b0);
    send(8'h75, 0);
    repeat (3) @(negedge clk);
    check("held_after_rst_75", held_cnt_a, 1);

    // Abandoned F0 prefix times out
    send(8'hF0, 0);
    repeat (10) @(negedge clk);
    check("seq_err_before_tmo", seq_err_a, 0);
    repeat (25) @(negedge clk);
    check("seq_err_after_tmo", seq_err_a, 1);
    expect_a(8'h15, 1'b0, 1'b0);
    send(8'h15, 0);
    wait_drain();
    check("held_after_tmo_15", held_cnt_a, 2);

    // Error byte: flag only, no event
    pulse_clr();
    check("clr_seq_err", seq_err_a, 0);
    send(8'h00, 0);
    repeat (3) @(negedge clk);
    check("seq_err_00", seq_err_a, 1);
    wait_drain();
    check("final_evt_ovf", evt_ovf_a, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
